// File: rtl/red_fetch_decode_if.sv
// Instruction-memory bus between the fetch unit (master) and a synchronous
// instruction RAM with one cycle of read latency (slave).
interface red_fetch_decode_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_en;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_addr, output imem_en, input imem_rdata);
  modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/red_fetch_decode.sv
// Three-stage (F, D, E) fetch/decode front end for the reduced RISC-V core;
// E-stage registers drive the datapath controls directly, branches resolve in E.
module red_fetch_decode #(
  parameter int                    ADDRESS_WIDTH = 5,
  parameter int                    ALUctrl_WIDTH = 3,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         Zero,
  red_fetch_decode_if.master           imem,
  output logic signed [DATA_WIDTH-1:0] ImmOp,
  output logic                         RegWrite,
  output logic                         MemWrite,
  output logic                         ALUsrc,
  output logic                         ResultSrc,
  output logic [ALUctrl_WIDTH-1:0]     ALUctrl,
  output logic [ADDRESS_WIDTH-1:0]     rs1,
  output logic [ADDRESS_WIDTH-1:0]     rs2,
  output logic [ADDRESS_WIDTH-1:0]     rd,
  output logic                         valid,
  output logic                         illegal
);

  localparam logic [ALUctrl_WIDTH-1:0] ALU_ADD = ALUctrl_WIDTH'(0);
  localparam logic [ALUctrl_WIDTH-1:0] ALU_SUB = ALUctrl_WIDTH'(1);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic                         legal;
    logic                         reg_write;
    logic                         mem_write;
    logic                         alu_src;
    logic                         result_src;
    logic                         is_br;
    logic                         is_bne;
    logic [ALUctrl_WIDTH-1:0]     alu_ctrl;
    logic [ADDRESS_WIDTH-1:0]     rs1;
    logic [ADDRESS_WIDTH-1:0]     rs2;
    logic [ADDRESS_WIDTH-1:0]     rd;
    logic signed [DATA_WIDTH-1:0] imm;
  } dec_t;

  // Unsupported encodings collapse to an all-zero bundle, i.e. a bubble.
  function automatic dec_t decode(input logic [DATA_WIDTH-1:0] inst);
    dec_t       d;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    opcode = inst[6:0];
    f3     = inst[14:12];
    f7     = inst[31:25];
    d      = '0;
    d.rs1  = ADDRESS_WIDTH'(inst[19:15]);
    d.rs2  = ADDRESS_WIDTH'(inst[24:20]);
    d.rd   = ADDRESS_WIDTH'(inst[11:7]);
    case (opcode)
      OP_R: if (f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
        d.legal     = 1'b1;
        d.reg_write = 1'b1;
        d.alu_ctrl  = f7[5] ? ALU_SUB : ALU_ADD;
      end
      OP_I, OP_LD: if ((opcode == OP_I && f3 == 3'b000) || (opcode == OP_LD && f3 == 3'b010)) begin
        d.legal      = 1'b1;
        d.reg_write  = 1'b1;
        d.alu_src    = 1'b1;
        d.result_src = (opcode == OP_LD);
        d.imm        = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
      end
      OP_ST: if (f3 == 3'b010) begin
        d.legal     = 1'b1;
        d.mem_write = 1'b1;
        d.alu_src   = 1'b1;
        d.rd        = '0;
        d.imm       = {{(DATA_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BR: if (f3[2:1] == 2'b00) begin
        d.legal    = 1'b1;
        d.is_br    = 1'b1;
        d.is_bne   = f3[0];
        d.alu_ctrl = ALU_SUB;
        d.rd       = '0;
        d.imm      = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      default: ;
    endcase
    if (d.rd == '0) d.reg_write = 1'b0;
    if (!d.legal) d = '0;
    return d;
  endfunction

  logic [DATA_WIDTH-1:0] pc_p0_q, pc_p0_d;
  logic [DATA_WIDTH-1:0] pc_p1_q;
  logic [DATA_WIDTH-1:0] pc_p2_q;
  logic [DATA_WIDTH-1:0] target_p2;
  logic                  vld_p1_q;
  logic                  ill_p2_q;
  logic                  vld_p2;
  logic                  taken_p2;
  logic                  keep_p1;
  dec_t                  dec_p1;
  dec_t                  e_p2_q;

  assign vld_p2 = e_p2_q.legal;

  always_comb begin
    dec_p1    = decode(imem.imem_rdata);
    target_p2 = pc_p2_q + $unsigned(e_p2_q.imm);
    taken_p2  = en && vld_p2 && e_p2_q.is_br && (e_p2_q.is_bne ^ Zero);
    keep_p1   = vld_p1_q && !taken_p2;
    pc_p0_d   = taken_p2 ? target_p2 : pc_p0_q + DATA_WIDTH'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0_q  <= RESET_PC;
      pc_p1_q  <= '0;
      pc_p2_q  <= '0;
      vld_p1_q <= 1'b0;
      ill_p2_q <= 1'b0;
      e_p2_q   <= '0;
    end else if (en) begin
      // F -> D: a taken branch kills the word currently being fetched
      pc_p0_q  <= pc_p0_d;
      pc_p1_q  <= pc_p0_q;
      vld_p1_q <= !taken_p2;
      // D -> E: a taken branch also kills the word being decoded
      pc_p2_q  <= pc_p1_q;
      ill_p2_q <= keep_p1 && !dec_p1.legal;
      e_p2_q   <= keep_p1 ? dec_p1 : '0;
    end
  end

  assign imem.imem_addr = pc_p0_q;
  assign imem.imem_en   = en;

  // Writes and status are masked while stalled; data fields keep their values.
  assign RegWrite  = e_p2_q.reg_write && en;
  assign MemWrite  = e_p2_q.mem_write && en;
  assign valid     = vld_p2 && en;
  assign illegal   = ill_p2_q && en;
  assign ImmOp     = e_p2_q.imm;
  assign ALUsrc    = e_p2_q.alu_src;
  assign ResultSrc = e_p2_q.result_src;
  assign ALUctrl   = e_p2_q.alu_ctrl;
  assign rs1       = e_p2_q.rs1;
  assign rs2       = e_p2_q.rs2;
  assign rd        = e_p2_q.rd;

endmodule

// File: tb/tb_red_fetch_decode.sv
// Bench for red_fetch_decode: decode vector table plus branch, stall and reset sequences,
// checked through an in-order scoreboard of the instructions expected on the E outputs.
module tb_red_fetch_decode;

  logic               clk = 1'b0;
  logic               rst, en, Zero;
  logic signed [31:0] ImmOp;
  logic               RegWrite, MemWrite, ALUsrc, ResultSrc, valid, illegal;
  logic [2:0]         ALUctrl;
  logic [4:0]         rs1, rs2, rd;

  red_fetch_decode_if #(.DATA_WIDTH(32)) imem_bus ();

  red_fetch_decode #(
    .ADDRESS_WIDTH(5), .ALUctrl_WIDTH(3), .DATA_WIDTH(32), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .Zero(Zero), .imem(imem_bus),
    .ImmOp(ImmOp), .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUsrc(ALUsrc),
    .ResultSrc(ResultSrc), .ALUctrl(ALUctrl), .rs1(rs1), .rs2(rs2), .rd(rd),
    .valid(valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) if (imem_bus.imem_en) imem_bus.imem_rdata <= mem[imem_bus.imem_addr[7:2]];

  typedef struct {
    logic [31:0] inst;
    logic        legal;
    logic [31:0] imm;
    logic        rw, mw, asrc, rsrc;
    logic [2:0]  ctrl;
    logic [4:0]  s1, s2, d;
  } vec_t;

  vec_t sb[$];
  vec_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  function automatic vec_t addi_v(input int k);
    vec_t v;
    v = '{32'h0, 1'b1, 32'(k), (k != 0), 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'(k), 5'(k)};
    v.inst = {12'(k), 5'd0, 3'b000, 5'(k), 7'h13};
    return v;
  endfunction

  function automatic vec_t ill_v(input logic [31:0] i);
    vec_t v;
    v = '{i, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0};
    return v;
  endfunction

  // bne x1,x2,-8
  function automatic vec_t bne_v();
    vec_t v;
    v = '{32'hFE209CE3, 1'b1, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 5'd1, 5'd2, 5'd0};
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_on && (valid || illegal)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got valid=%0b illegal=%0b rd=%0d, required no E output", valid, illegal, rd);
      end else begin
        mon_e = sb.pop_front();
        if ({valid, illegal, ImmOp, RegWrite, MemWrite, ALUsrc, ResultSrc, ALUctrl, rs1, rs2, rd} !==
            {mon_e.legal, !mon_e.legal, mon_e.imm, mon_e.rw, mon_e.mw, mon_e.asrc, mon_e.rsrc,
             mon_e.ctrl, mon_e.s1, mon_e.s2, mon_e.d}) begin
          n_fail++;
          $display("FAIL sb_%08h: got v=%0b il=%0b imm=%08h rw=%0b mw=%0b as=%0b rs=%0b ctrl=%0d rs1=%0d rs2=%0d rd=%0d, required v=%0b il=%0b imm=%08h rw=%0b mw=%0b as=%0b rs=%0b ctrl=%0d rs1=%0d rs2=%0d rd=%0d",
                   mon_e.inst, valid, illegal, ImmOp, RegWrite, MemWrite, ALUsrc, ResultSrc, ALUctrl, rs1, rs2, rd,
                   mon_e.legal, !mon_e.legal, mon_e.imm, mon_e.rw, mon_e.mw, mon_e.asrc, mon_e.rsrc,
                   mon_e.ctrl, mon_e.s1, mon_e.s2, mon_e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) mem[i] = 32'h00000013;
  endtask

  task automatic load_branch_prog();
    fill_nop();
    for (int k = 1; k <= 4; k++) mem[k-1] = addi_v(k).inst;
    mem[4] = bne_v().inst;
    mem[5] = addi_v(5).inst;
    mem[6] = addi_v(6).inst;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    rst    = 1'b1;
    en     = 1'b1;
    tick();
    rst    = 1'b0;
    sb.delete();
    mon_on = 1'b1;
  endtask

  task automatic drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    check(name, 64'(sb.size()), 64'(0));
    mon_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [9];
    tbl[0] = '{32'h00500513, 1'b1, 32'd5,        1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd5,  5'd10};
    tbl[1] = '{32'h003100B3, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd2, 5'd3,  5'd1};
    tbl[2] = '{32'h403100B3, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 5'd2, 5'd3,  5'd1};
    tbl[3] = '{32'h00A02423, 1'b1, 32'd8,        1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 5'd10, 5'd0};
    tbl[4] = '{32'hFFC12583, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 5'd2, 5'd28, 5'd11};
    tbl[5] = ill_v(32'hFFFFFFFF);
    tbl[6] = '{32'h00100013, 1'b1, 32'd1,        1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd1,  5'd0};
    tbl[7] = '{32'h00208463, 1'b1, 32'd8,        1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 5'd1, 5'd2,  5'd0};
    tbl[8] = ill_v(32'h003110B3);

    fill_nop();
    for (int i = 0; i < 9; i++) mem[i] = tbl[i].inst;

    // Reset held two cycles with en=1 and Zero=1
    rst = 1'b1; en = 1'b1; Zero = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      check("rst_outputs", 64'({ImmOp, RegWrite, MemWrite, ALUsrc, ResultSrc, ALUctrl, rs1, rs2, rd, valid, illegal}), 64'(0));
      check("rst_imem_addr", 64'(imem_bus.imem_addr), 64'(0));
      check("rst_imem_en", 64'(imem_bus.imem_en), 64'(1));
    end
    rst = 1'b0; Zero = 1'b0;
    for (int i = 0; i < 9; i++) sb.push_back(tbl[i]);
    mon_on = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("boot_imem_addr", 64'(imem_bus.imem_addr), 64'(c * 4));
      check("boot_valid", 64'(valid), 64'(c == 2));
      if (c < 2) tick();
    end
    drain("decode_table_drained", 12);

    // Taken bne at 0x10 back to 0x08
    Zero = 1'b0;
    load_branch_prog();
    do_reset();
    for (int k = 1; k <= 4; k++) sb.push_back(addi_v(k));
    sb.push_back(bne_v());
    sb.push_back(addi_v(3));
    sb.push_back(addi_v(4));
    sb.push_back(bne_v());
    for (int c = 0; c < 13; c++) begin
      if (c == 7) check("taken_imem_addr", 64'(imem_bus.imem_addr), 64'h8);
      if (c == 7 || c == 8) check("taken_bubble", 64'({valid, RegWrite, MemWrite, illegal}), 64'(0));
      tick();
    end
    drain("taken_drained", 2);

    // Not-taken bne: straight-line flow with no bubble
    Zero = 1'b1;
    load_branch_prog();
    do_reset();
    for (int k = 1; k <= 4; k++) sb.push_back(addi_v(k));
    sb.push_back(bne_v());
    sb.push_back(addi_v(5));
    sb.push_back(addi_v(6));
    for (int c = 0; c < 9; c++) begin
      if (c >= 2) check("not_taken_valid", 64'(valid), 64'(1));
      if (c == 7) check("not_taken_imem_addr", 64'(imem_bus.imem_addr), 64'h1C);
      tick();
    end
    drain("not_taken_drained", 2);

    // Three-cycle stall mid-stream
    Zero = 1'b0;
    fill_nop();
    for (int k = 1; k <= 8; k++) mem[k-1] = addi_v(k).inst;
    do_reset();
    for (int k = 1; k <= 8; k++) sb.push_back(addi_v(k));
    for (int c = 0; c < 13; c++) begin
      en = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 6) begin
        check("stall_imem_addr", 64'(imem_bus.imem_addr), 64'h10);
        check("stall_imem_en", 64'(imem_bus.imem_en), 64'(0));
        check("stall_mask", 64'({valid, RegWrite, MemWrite, illegal}), 64'(0));
      end
      tick();
    end
    en = 1'b1;
    drain("stall_drained", 2);

    // Reset lands while a would-be-taken bne sits in E
    Zero = 1'b0;
    load_branch_prog();
    do_reset();
    for (int k = 1; k <= 4; k++) sb.push_back(addi_v(k));
    sb.push_back(bne_v());
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    check("rst_in_e_imem_addr", 64'(imem_bus.imem_addr), 64'(0));
    check("rst_in_e_valid", 64'(valid), 64'(0));
    check("rst_in_e_consumed", 64'(sb.size()), 64'(0));
    rst = 1'b0;
    sb.delete();
    for (int k = 1; k <= 4; k++) sb.push_back(addi_v(k));
    for (int c = 0; c < 6; c++) tick();
    drain("rst_in_e_restart", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
